// File: rtl/chacha20_key_store.sv
// chacha20_key_store: in-order 256-bit key assembly with lock handshake and zeroizing wipe
module chacha20_key_store (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_write_enable,
  input  logic [2:0]   key_index,
  input  logic [31:0]  chacha20_key,
  input  logic         key_ready,
  input  logic         core_start,
  input  logic         core_done,
  input  logic         rekey,
  output logic [255:0] key_out,
  output logic         key_valid,
  output logic         key_locked,
  output logic         key_empty,
  output logic [3:0]   words_loaded,
  output logic         seq_error
);
  typedef enum logic [2:0] {EMPTY, FILLING, FULL, BUSY, WIPE} state_t;
  state_t state_q, state_d;
  logic [7:0][31:0] key_q, key_d;
  logic [2:0] exp_q, exp_d, wipe_q, wipe_d;
  logic [3:0] words_q, words_d;
  logic pend_q, pend_d, err_q, err_d;
  logic valid_q, locked_q, empty_q;
  logic loading;
  // next-state: rekey in an unlocked state overrides everything, otherwise per-state handling
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    exp_d   = exp_q;
    wipe_d  = wipe_q;
    words_d = words_q;
    pend_d  = pend_q;
    err_d   = err_q;
    loading = state_q == EMPTY || state_q == FILLING;
    if ((loading && key_ready) || (core_start && state_q != FULL) || (core_done && state_q != BUSY))
      err_d = 1'b1;
    if (rekey && (loading || state_q == FULL)) begin
      state_d = WIPE;
      wipe_d  = 3'd0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY, FILLING: begin
          if (key_write_enable && key_index == exp_q) begin
            key_d[key_index] = chacha20_key;
            exp_d   = exp_q + 3'd1;
            words_d = words_q + 4'd1;
            state_d = exp_q == 3'd7 ? FULL : FILLING;
          end else if (key_write_enable) begin
            err_d = 1'b1;
          end
        end
        FULL: begin
          if (key_write_enable) err_d = 1'b1;
          if (core_start) state_d = BUSY;
        end
        BUSY: begin
          if (key_write_enable) err_d = 1'b1;
          if (rekey) pend_d = 1'b1;
          if (core_done && (rekey || pend_q)) begin
            state_d = WIPE;
            wipe_d  = 3'd0;
            pend_d  = 1'b0;
            err_d   = 1'b0;
          end else if (core_done) begin
            state_d = FULL;
          end
        end
        WIPE: begin
          if (key_write_enable) err_d = 1'b1;
          key_d[wipe_q] = 32'd0;
          wipe_d = wipe_q + 3'd1;
          if (wipe_q == 3'd7) begin
            state_d = EMPTY;
            exp_d   = 3'd0;
            words_d = 4'd0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // state, key and status registers; status flags are decoded from next state so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      key_q    <= '0;
      exp_q    <= 3'd0;
      wipe_q   <= 3'd0;
      words_q  <= 4'd0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      exp_q    <= exp_d;
      wipe_q   <= wipe_d;
      words_q  <= words_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      valid_q  <= state_d == FULL || state_d == BUSY;
      locked_q <= state_d == BUSY;
      empty_q  <= state_d == EMPTY;
    end
  end
  assign key_out      = valid_q ? key_q : 256'd0;
  assign key_valid    = valid_q;
  assign key_locked   = locked_q;
  assign key_empty    = empty_q;
  assign words_loaded = words_q;
  assign seq_error    = err_q;
endmodule

// File: tb/tb_chacha20_key_store.sv
// tb_chacha20_key_store: scoreboard bench for the key store load/lock/wipe protocol
module tb_chacha20_key_store;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_write_enable = 1'b0;
  logic [2:0]   key_index = 3'd0;
  logic [31:0]  chacha20_key = 32'd0;
  logic         key_ready = 1'b0;
  logic         core_start = 1'b0;
  logic         core_done = 1'b0;
  logic         rekey = 1'b0;
  logic [255:0] key_out;
  logic         key_valid, key_locked, key_empty, seq_error;
  logic [3:0]   words_loaded;
  typedef struct packed {
    logic         v;
    logic         l;
    logic         e;
    logic [3:0]   w;
    logic         err;
    logic [255:0] key;
  } snap_t;
  snap_t sb[$];
  int total = 0;
  int bad = 0;
  int step = 0;
  logic [255:0] key_a, key_b;
  chacha20_key_store dut (
    .clk(clk), .rst_n(rst_n), .key_write_enable(key_write_enable), .key_index(key_index),
    .chacha20_key(chacha20_key), .key_ready(key_ready), .core_start(core_start),
    .core_done(core_done), .rekey(rekey), .key_out(key_out), .key_valid(key_valid),
    .key_locked(key_locked), .key_empty(key_empty), .words_loaded(words_loaded),
    .seq_error(seq_error)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input int i, input logic [31:0] x);
    return (32'h03020100 + 32'(i) * 32'h04040404) ^ x;
  endfunction
  function automatic logic [255:0] mk(input logic [31:0] x);
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = word(i, x);
    return k;
  endfunction
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL step %0d %s: got %h want %h", step, tag, got, exp);
    end
  endtask
  task automatic expect_out(input logic v, l, e, input logic [3:0] w, input logic err, input logic [255:0] key);
    sb.push_back('{v: v, l: l, e: e, w: w, err: err, key: key});
  endtask
  task automatic check_now();
    snap_t s;
    if (sb.size() == 0) return;
    s = sb.pop_front();
    chk("key_valid", 256'(key_valid), 256'(s.v));
    chk("key_locked", 256'(key_locked), 256'(s.l));
    chk("key_empty", 256'(key_empty), 256'(s.e));
    chk("words_loaded", 256'(words_loaded), 256'(s.w));
    chk("seq_error", 256'(seq_error), 256'(s.err));
    chk("key_out", key_out, s.key);
  endtask
  task automatic cyc(input logic we, input logic [2:0] idx, input logic [31:0] d,
                     input logic kr, input logic cs, input logic cd, input logic rk);
    key_write_enable = we;
    key_index = idx;
    chacha20_key = d;
    key_ready = kr;
    core_start = cs;
    core_done = cd;
    rekey = rk;
    @(posedge clk);
    #1;
    step++;
    key_write_enable = 1'b0;
    key_ready = 1'b0;
    core_start = 1'b0;
    core_done = 1'b0;
    rekey = 1'b0;
    check_now();
  endtask
  initial begin
    key_a = mk(32'd0);
    key_b = mk(32'hA5A5A5A5);
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, 0, 1, 0, 0, 0);
    check_now();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_out(i == 7, 0, 0, 4'(i + 1), 0, i == 7 ? key_a : 256'd0);
      cyc(1, 3'(i), word(i, 0), 0, 0, 0, 0);
    end
    chk("key_lo", 256'(key_out[31:0]), 256'h03020100);
    chk("key_hi", 256'(key_out[255:224]), 256'h1F1E1D1C);
    expect_out(1, 1, 0, 8, 0, key_a);
    cyc(0, 0, 0, 0, 1, 0, 0);
    expect_out(1, 1, 0, 8, 1, key_a);
    cyc(1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    expect_out(1, 1, 0, 8, 1, key_a);
    cyc(0, 0, 0, 0, 0, 0, 1);
    expect_out(0, 0, 0, 8, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      expect_out(0, 0, i == 7, i == 7 ? 4'd0 : 4'd8, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    expect_out(0, 0, 0, 1, 0, 0);
    cyc(1, 0, word(0, 0), 0, 0, 0, 0);
    expect_out(0, 0, 0, 1, 1, 0);
    cyc(1, 2, word(2, 0), 0, 0, 0, 0);
    expect_out(0, 0, 0, 2, 1, 0);
    cyc(1, 1, word(1, 0), 0, 0, 0, 0);
    expect_out(0, 0, 0, 3, 1, 0);
    cyc(1, 2, word(2, 0), 0, 0, 0, 0);
    expect_out(0, 0, 0, 3, 0, 0);
    cyc(1, 3, word(3, 0), 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      expect_out(0, 0, i == 7, i == 7 ? 4'd0 : 4'd3, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      expect_out(0, 0, 0, 4'(i + 1), 0, 0);
      cyc(1, 3'(i), word(i, 0), 0, 0, 0, 0);
    end
    expect_out(0, 0, 0, 5, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int i = 5; i < 8; i++) begin
      expect_out(i == 7, 0, 0, 4'(i + 1), 1, i == 7 ? key_a : 256'd0);
      cyc(1, 3'(i), word(i, 0), 0, 0, 0, 0);
    end
    expect_out(0, 0, 0, 8, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      expect_out(0, 0, 0, 8, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    rst_n = 1'b0;
    #1;
    expect_out(0, 0, 1, 0, 0, 0);
    check_now();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_out(i == 7, 0, 0, 4'(i + 1), 0, i == 7 ? key_b : 256'd0);
      cyc(1, 3'(i), word(i, 32'hA5A5A5A5), 0, 0, 0, 0);
    end
    expect_out(1, 0, 0, 8, 1, key_b);
    cyc(0, 0, 0, 0, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
